// File: rtl/nco_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : nco_sweep_ctrl_if
// Brief    : Configuration, control and NCO-drive bundle for nco_sweep_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface nco_sweep_ctrl_if #(
    parameter int LUTSIZE = 8,
    parameter int DWELL_W = 16
);
    localparam int FTW_W = LUTSIZE + 9;

    logic               cfg_valid;
    logic               cfg_ready;
    logic [FTW_W-1:0]   cfg_start_ftw;
    logic [FTW_W-1:0]   cfg_stop_ftw;
    logic [FTW_W-1:0]   cfg_step;
    logic [DWELL_W-1:0] cfg_dwell;
    logic [1:0]         cfg_mode;
    logic               start;
    logic               abort;
    logic [LUTSIZE:0]   iftw;
    logic [7:0]         fftw;
    logic               nco_en;
    logic               busy;
    logic               sweep_dir;
    logic               wrap;
    logic               done;

    modport master (
        output cfg_valid, cfg_start_ftw, cfg_stop_ftw, cfg_step, cfg_dwell, cfg_mode,
        output start, abort,
        input  cfg_ready, iftw, fftw, nco_en, busy, sweep_dir, wrap, done
    );

    modport slave (
        input  cfg_valid, cfg_start_ftw, cfg_stop_ftw, cfg_step, cfg_dwell, cfg_mode,
        input  start, abort,
        output cfg_ready, iftw, fftw, nco_en, busy, sweep_dir, wrap, done
    );
endinterface
`default_nettype wire

// File: rtl/nco_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nco_sweep_ctrl
// Brief    : NCO frequency-sweep sequencer (single chirp / sawtooth / triangle).
// Revision : 1.0 - initial release
// ============================================================================
module nco_sweep_ctrl #(
    parameter int LUTSIZE = 8,
    parameter int DWELL_W = 16
) (
    input  wire logic        clk,
    input  wire logic        rst,
    nco_sweep_ctrl_if.slave  sw
);
    localparam int FTW_W = LUTSIZE + 9;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [FTW_W-1:0]   r_ftw, w_ftw_nxt;
    logic [DWELL_W-1:0] r_dwell_cnt, w_dwell_nxt;
    logic               r_dir, w_dir_nxt;
    logic               r_wrap, w_wrap_nxt;
    logic               r_done, w_done_nxt;

    logic [FTW_W-1:0]   r_cfg_start;
    logic [FTW_W-1:0]   r_cfg_stop;
    logic [FTW_W-1:0]   r_cfg_step;
    logic [DWELL_W-1:0] r_cfg_dwell;
    logic [1:0]         r_cfg_mode;
    logic               r_cfg_loaded;

    logic               w_cfg_accept;
    logic [FTW_W-1:0]   w_eff_stop;
    logic [FTW_W:0]     w_up_sum;
    logic [FTW_W:0]     w_dn_diff;
    logic [FTW_W-1:0]   w_up_ftw;
    logic [FTW_W-1:0]   w_dn_ftw;

    assign w_cfg_accept = sw.cfg_valid && (r_state == ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cfg_start  <= '0;
            r_cfg_stop   <= '0;
            r_cfg_step   <= '0;
            r_cfg_dwell  <= '0;
            r_cfg_mode   <= '0;
            r_cfg_loaded <= 1'b0;
        end else if (w_cfg_accept) begin
            r_cfg_start  <= sw.cfg_start_ftw;
            r_cfg_stop   <= sw.cfg_stop_ftw;
            r_cfg_step   <= sw.cfg_step;
            r_cfg_dwell  <= sw.cfg_dwell;
            r_cfg_mode   <= sw.cfg_mode;
            r_cfg_loaded <= 1'b1;
        end
    end

    // A stop at or below start collapses the sweep onto the start tone.
    assign w_eff_stop = (r_cfg_stop > r_cfg_start) ? r_cfg_stop : r_cfg_start;
    assign w_up_sum   = {1'b0, r_ftw} + {1'b0, r_cfg_step};
    assign w_dn_diff  = {1'b0, r_ftw} - {1'b0, r_cfg_step};
    assign w_up_ftw   = (w_up_sum >= {1'b0, w_eff_stop}) ? w_eff_stop : w_up_sum[FTW_W-1:0];
    assign w_dn_ftw   = (w_dn_diff[FTW_W] || (w_dn_diff[FTW_W-1:0] <= r_cfg_start))
                        ? r_cfg_start : w_dn_diff[FTW_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ftw       <= '0;
            r_dwell_cnt <= '0;
            r_dir       <= 1'b0;
            r_wrap      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ftw       <= w_ftw_nxt;
            r_dwell_cnt <= w_dwell_nxt;
            r_dir       <= w_dir_nxt;
            r_wrap      <= w_wrap_nxt;
            r_done      <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ftw_nxt   = r_ftw;
        w_dwell_nxt = r_dwell_cnt;
        w_dir_nxt   = r_dir;
        w_wrap_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (sw.start && r_cfg_loaded && !sw.abort) begin
                    w_state_nxt = ST_RUN;
                    w_ftw_nxt   = r_cfg_start;
                    w_dwell_nxt = r_cfg_dwell;
                    w_dir_nxt   = 1'b0;
                end
            end
            ST_RUN: begin
                if (sw.abort) begin
                    w_state_nxt = ST_IDLE;
                    w_dir_nxt   = 1'b0;
                end else if (r_dwell_cnt != '0) begin
                    w_dwell_nxt = r_dwell_cnt - 1'b1;
                end else begin
                    w_dwell_nxt = r_cfg_dwell;
                    if (!r_dir) begin
                        if (r_ftw == w_eff_stop) begin
                            case (r_cfg_mode)
                                2'd1: begin
                                    w_ftw_nxt  = r_cfg_start;
                                    w_wrap_nxt = 1'b1;
                                end
                                2'd2: begin
                                    w_dir_nxt  = 1'b1;
                                    w_wrap_nxt = 1'b1;
                                    w_ftw_nxt  = w_dn_ftw;
                                end
                                default: begin
                                    w_state_nxt = ST_IDLE;
                                    w_done_nxt  = 1'b1;
                                end
                            endcase
                        end else begin
                            w_ftw_nxt = w_up_ftw;
                        end
                    end else if (r_ftw == r_cfg_start) begin
                        w_dir_nxt  = 1'b0;
                        w_wrap_nxt = 1'b1;
                        w_ftw_nxt  = w_up_ftw;
                    end else begin
                        w_ftw_nxt = w_dn_ftw;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign sw.cfg_ready = (r_state == ST_IDLE);
    assign sw.iftw      = r_ftw[FTW_W-1:8];
    assign sw.fftw      = r_ftw[7:0];
    assign sw.nco_en    = (r_state == ST_RUN);
    assign sw.busy      = (r_state == ST_RUN);
    assign sw.sweep_dir = r_dir;
    assign sw.wrap      = r_wrap;
    assign sw.done      = r_done;
endmodule
`default_nettype wire

// File: tb/tb_nco_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nco_sweep_ctrl
// Brief    : Directed vector bench for nco_sweep_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nco_sweep_ctrl;
    localparam int LUTSIZE = 8;
    localparam int DWELL_W = 16;
    localparam int FTW_W   = LUTSIZE + 9;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    nco_sweep_ctrl_if #(.LUTSIZE(LUTSIZE), .DWELL_W(DWELL_W)) sw ();
    nco_sweep_ctrl #(.LUTSIZE(LUTSIZE), .DWELL_W(DWELL_W)) dut (
        .clk (clk),
        .rst (rst),
        .sw  (sw)
    );

    typedef struct {
        logic             start;
        logic             abort;
        logic [FTW_W-1:0] ftw;
        logic             busy;
        logic             wrap;
        logic             done;
        logic             dir;
    } vec_t;

    vec_t vq[$];

    function automatic void push(logic s, logic a, logic [FTW_W-1:0] f,
                                 logic b, logic w, logic d, logic dr);
        vec_t v;
        v.start = s; v.abort = a; v.ftw = f;
        v.busy  = b; v.wrap  = w; v.done = d; v.dir = dr;
        vq.push_back(v);
    endfunction

    function automatic logic [31:0] obs();
        return {10'd0, sw.iftw, sw.fftw, sw.busy, sw.nco_en, sw.wrap, sw.done, sw.sweep_dir};
    endfunction

    function automatic logic [31:0] expv(logic [FTW_W-1:0] f, logic b, logic w, logic d, logic dr);
        return {10'd0, f, b, b, w, d, dr};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Each vector drives start/abort for one edge, then compares the post-edge outputs.
    task automatic run_vecs(string tag);
        foreach (vq[i]) begin
            sw.start = vq[i].start;
            sw.abort = vq[i].abort;
            @(posedge clk); #1;
            sw.start = 1'b0;
            sw.abort = 1'b0;
            check($sformatf("%s[%0d]", tag, i), obs(),
                  expv(vq[i].ftw, vq[i].busy, vq[i].wrap, vq[i].done, vq[i].dir));
        end
        vq.delete();
    endtask

    task automatic cfg_write(logic [FTW_W-1:0] s, logic [FTW_W-1:0] e, logic [FTW_W-1:0] st,
                             logic [DWELL_W-1:0] dw, logic [1:0] m);
        int k;
        sw.cfg_start_ftw = s;
        sw.cfg_stop_ftw  = e;
        sw.cfg_step      = st;
        sw.cfg_dwell     = dw;
        sw.cfg_mode      = m;
        sw.cfg_valid     = 1'b1;
        k = 0;
        while (!sw.cfg_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (!sw.cfg_ready) check("cfg_ready_wait", 32'(sw.cfg_ready), 32'd1);
        @(posedge clk); #1;
        sw.cfg_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        sw.cfg_valid = 1'b0; sw.cfg_start_ftw = '0; sw.cfg_stop_ftw = '0;
        sw.cfg_step = '0; sw.cfg_dwell = '0; sw.cfg_mode = '0;
        sw.start = 1'b0; sw.abort = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_outputs", obs(), 32'd0);
        check("reset_cfg_ready", 32'(sw.cfg_ready), 32'd1);

        // Start with nothing configured is ignored.
        push(1, 0, 17'h0, 0, 0, 0, 0);
        push(0, 0, 17'h0, 0, 0, 0, 0);
        run_vecs("nocfg");

        // Single chirp, step 0x100, dwell 2.
        cfg_write(17'h00100, 17'h00400, 17'h00100, 16'd2, 2'd0);
        push(1, 0, 17'h100, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++) push(0, 0, 17'h100, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) push(0, 0, 17'h200, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) push(0, 0, 17'h300, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) push(0, 0, 17'h400, 1, 0, 0, 0);
        push(0, 0, 17'h400, 0, 0, 1, 0);
        push(0, 0, 17'h400, 0, 0, 0, 0);
        run_vecs("chirp");

        // Single chirp with clamped final step.
        cfg_write(17'h00100, 17'h00400, 17'h00180, 16'd2, 2'd0);
        push(1, 0, 17'h100, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++) push(0, 0, 17'h100, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) push(0, 0, 17'h280, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) push(0, 0, 17'h400, 1, 0, 0, 0);
        push(0, 0, 17'h400, 0, 0, 1, 0);
        run_vecs("clamp");

        // Triangle, dwell 0, then abort.
        cfg_write(17'h00100, 17'h00200, 17'h00100, 16'd0, 2'd2);
        push(1, 0, 17'h100, 1, 0, 0, 0);
        push(0, 0, 17'h200, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            if (i % 2 == 0) push(0, 0, 17'h100, 1, 1, 0, 1);
            else            push(0, 0, 17'h200, 1, 1, 0, 0);
        push(0, 1, 17'h200, 0, 0, 0, 0);
        push(0, 0, 17'h200, 0, 0, 0, 0);
        run_vecs("tri");

        // Degenerate single: stop below start ends after one dwell.
        cfg_write(17'h00300, 17'h00200, 17'h00100, 16'd1, 2'd0);
        push(1, 0, 17'h300, 1, 0, 0, 0);
        push(0, 0, 17'h300, 1, 0, 0, 0);
        push(0, 0, 17'h300, 0, 0, 1, 0);
        run_vecs("degen0");

        // Degenerate sawtooth: tone held, wrap every dwell+1 cycles.
        cfg_write(17'h00300, 17'h00300, 17'h00100, 16'd1, 2'd1);
        push(1, 0, 17'h300, 1, 0, 0, 0);
        push(0, 0, 17'h300, 1, 0, 0, 0);
        push(0, 0, 17'h300, 1, 1, 0, 0);
        push(0, 0, 17'h300, 1, 0, 0, 0);
        push(0, 0, 17'h300, 1, 1, 0, 0);
        push(0, 1, 17'h300, 0, 0, 0, 0);
        run_vecs("degen1");

        // Sawtooth near the top of the tuning range: clamp, no modular wrap.
        cfg_write(17'h1FF00, 17'h1FFFF, 17'h00200, 16'd1, 2'd1);
        push(1, 0, 17'h1FF00, 1, 0, 0, 0);
        push(0, 0, 17'h1FF00, 1, 0, 0, 0);
        push(0, 0, 17'h1FFFF, 1, 0, 0, 0);
        push(0, 0, 17'h1FFFF, 1, 0, 0, 0);
        push(0, 0, 17'h1FF00, 1, 1, 0, 0);
        run_vecs("saw");

        // Abort together with a config presentation; config lands the next cycle.
        sw.cfg_start_ftw = 17'h00300; sw.cfg_stop_ftw = 17'h00500;
        sw.cfg_step = 17'h00100; sw.cfg_dwell = 16'd0; sw.cfg_mode = 2'd0;
        sw.cfg_valid = 1'b1;
        sw.abort = 1'b1;
        @(posedge clk); #1;
        sw.abort = 1'b0;
        check("abort_outputs", obs(), expv(17'h1FF00, 0, 0, 0, 0));
        check("abort_cfg_ready", 32'(sw.cfg_ready), 32'd1);
        // Start coincident with the accept runs the previous config.
        sw.start = 1'b1;
        @(posedge clk); #1;
        sw.start = 1'b0;
        sw.cfg_valid = 1'b0;
        check("start_old_cfg", obs(), expv(17'h1FF00, 1, 0, 0, 0));
        @(posedge clk); #1;
        check("old_cfg_dwell", obs(), expv(17'h1FF00, 1, 0, 0, 0));
        push(0, 1, 17'h1FF00, 0, 0, 0, 0);
        push(1, 0, 17'h00300, 1, 0, 0, 0);
        push(0, 0, 17'h00400, 1, 0, 0, 0);
        push(0, 0, 17'h00500, 1, 0, 0, 0);
        push(0, 0, 17'h00500, 0, 0, 1, 0);
        run_vecs("newcfg");

        // Asynchronous reset mid-sweep clears outputs and the loaded config.
        cfg_write(17'h00100, 17'h00400, 17'h00100, 16'd2, 2'd0);
        push(1, 0, 17'h100, 1, 0, 0, 0);
        push(0, 0, 17'h100, 1, 0, 0, 0);
        run_vecs("prerst");
        #2 rst = 1'b1;
        #1;
        check("async_rst_outputs", obs(), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        push(1, 0, 17'h0, 0, 0, 0, 0);
        push(0, 0, 17'h0, 0, 0, 0, 0);
        run_vecs("postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/nco_sweep_ctrl.md
Name: nco_sweep_ctrl

Overview:
Frequency-sweep sequencer for the phase-accumulator NCO. It holds a programmed sweep of start FTW, stop FTW, step and dwell. It steps the NCO tuning word through that sweep (single chirp, sawtooth repeat, or triangle) and drives the NCO's integer/fraction FTW inputs and its enable. Configuration is written through a valid/ready port while the sweep is idle.

Parameters:
LUTSIZE, 8, sine LUT address width; integer FTW is LUTSIZE+1 bits, fraction 8 bits
DWELL_W, 16, width of dwell counter
(derived, not overridable) FTW_W = LUTSIZE+9, full tuning-word width {integer, fraction}

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
cfg_valid  in  1  config word presented
cfg_ready  out  1  config accepted this cycle when cfg_valid&cfg_ready
cfg_start_ftw  in  FTW_W  sweep start tuning word
cfg_stop_ftw  in  FTW_W  sweep end tuning word
cfg_step  in  FTW_W  unsigned increment per step
cfg_dwell  in  DWELL_W  each FTW held dwell+1 cycles
cfg_mode  in  2  0=single, 1=sawtooth repeat, 2=triangle, 3=reserved (treated as 0)
start  in  1  begin sweep (pulse)
abort  in  1  stop sweep immediately (pulse)
iftw  out  LUTSIZE+1  integer FTW to NCO = ftw[FTW_W-1:8]
fftw  out  8  fractional FTW to NCO = ftw[7:0]
nco_en  out  1  NCO enable
busy  out  1  sweep active
sweep_dir  out  1  0=up, 1=down (triangle only; 0 otherwise)
wrap  out  1  1-cycle pulse at each sawtooth restart / triangle turn
done  out  1  1-cycle pulse at single-sweep completion

Behaviour:
- Reset: state IDLE; ftw, iftw, fftw, nco_en, busy, sweep_dir, wrap, done = 0; config regs = 0; cfg_loaded = 0.
- cfg_ready = (state==IDLE), combinational; therefore 1 immediately after reset.
- Config handshake: cfg_valid&cfg_ready latches all cfg_* and sets cfg_loaded. cfg_valid while busy is not accepted and must be held by the source.
- States: IDLE, RUN.
- IDLE -> RUN: start & cfg_loaded & !abort. start without cfg_loaded is ignored.
- A start in the same cycle as a config accept uses the previously latched config; the new config applies to the next start.
- Start latency: start sampled at edge t. From t+1: ftw = start_ftw, nco_en = 1, busy = 1, sweep_dir = 0, dwell_cnt = cfg_dwell.
- RUN dwell: if dwell_cnt != 0, decrement. If 0, perform a step and reload dwell_cnt = cfg_dwell. Each FTW value is visible for exactly dwell+1 cycles.
- Step arithmetic is computed in FTW_W+1 bits, with no modular wrap.
  - Up: nxt = ftw + step; if nxt >= stop_ftw, ftw <= stop_ftw (clamp).
  - Down: nxt = ftw - step; if nxt <= start_ftw or borrow, ftw <= start_ftw.
- End of segment (dwell expiry while ftw == stop_ftw going up):
  - mode 0/3: state IDLE; nco_en = 0, busy = 0, done = 1 for one cycle; iftw/fftw hold last value.
  - mode 1: ftw <= start_ftw, wrap = 1.
  - mode 2: sweep_dir <= 1, wrap = 1, ftw <= first down step.
- Triangle bottom: dwell expiry while ftw == start_ftw with sweep_dir = 1 gives sweep_dir <= 0, wrap = 1, ftw <= first up step. A triangle never produces done.
- Degenerate cases:
  - stop_ftw <= start_ftw: ftw stays start_ftw. mode 0 ends after the first dwell with done. Modes 1/2 hold the tone and pulse wrap every dwell+1 cycles until abort.
  - step == 0 with stop > start: ftw never advances; runs until abort; no done or wrap.
- abort, any state: next edge state IDLE; nco_en = 0, busy = 0, sweep_dir = 0. No done or wrap. iftw/fftw hold. abort has priority over start and over step/end events in the same cycle.
- rst mid-sweep: all outputs zero asynchronously; cfg_loaded is cleared, so a reconfigure is required.

Test Plan:
1. LUTSIZE=8; cfg start=0x00100, stop=0x00400, step=0x00100, dwell=2, mode 0; start at t0. Expect ftw 0x100 at t1-t3, 0x200 at t4-t6, 0x300 at t7-t9, 0x400 at t10-t12. At t13: done=1, nco_en=0, busy=0, iftw=4, fftw=0.
2. Same cfg with step=0x180. Expect ftw 0x100, 0x280, then 0x400 (clamped), each 3 cycles, then done.
3. start=0x100, stop=0x200, step=0x100, dwell=0, mode 2. Expect per-cycle ftw 0x100, 0x200, 0x100, 0x200 …, with wrap=1 on each turn, sweep_dir toggling, and done never asserting.
4. start=0x1FF00, stop=0x1FFFF, step=0x00200, mode 1. Expect ftw 0x1FF00 then 0x1FFFF (no wrap to 0x000xx), then 0x1FF00 with wrap=1.
5. Mode 1 running; assert abort together with cfg_valid. Next cycle: busy=0, nco_en=0, done=0, wrap=0, ftw held. Config is accepted the cycle after (cfg_ready=1).
6. Start before any config: no change, busy stays 0. Assert rst mid-sweep: outputs 0 immediately; a subsequent start is ignored until reconfigured.
